// File: rtl/reg_bank_arbiter_if.sv
// Host-side request/response bundle for both requesters plus the shared
// register bank port. The arbiter attaches through the slave modport.
interface reg_bank_arbiter_if #(
    parameter int REG_WIDTH = 8,
    parameter int ADDR_W    = 4
);
    logic [1:0]             req;
    logic [1:0]             lock;
    logic [1:0]             wr_rdn;
    logic [2*ADDR_W-1:0]    addr;
    logic [2*REG_WIDTH-1:0] wdata;
    logic [1:0]             ack;
    logic [1:0]             err;
    logic [REG_WIDTH-1:0]   rdata;

    logic                   bank_wr_rdn;
    logic [ADDR_W-1:0]      bank_addr;
    logic [REG_WIDTH-1:0]   bank_wdata;
    logic                   bank_we;
    logic [REG_WIDTH-1:0]   bank_rdata;
    logic                   bank_err;

    // Hosts and the register bank together form the environment around the arbiter.
    modport master (
        output req, lock, wr_rdn, addr, wdata, bank_rdata, bank_err,
        input  ack, err, rdata, bank_wr_rdn, bank_addr, bank_wdata, bank_we
    );

    modport slave (
        input  req, lock, wr_rdn, addr, wdata, bank_rdata, bank_err,
        output ack, err, rdata, bank_wr_rdn, bank_addr, bank_wdata, bank_we
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Two-requester arbiter onto a single register bank port: IDLE/ISSUE/RESP
// serialisation, round-robin or fixed priority, owner lock with idle timeout.
module reg_bank_arbiter #(
    parameter int REG_WIDTH    = 8,
    parameter int ADDR_W       = 4,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               ena,
    input  logic               prio_mode,
    output logic               timeout,
    reg_bank_arbiter_if.slave  bus
);
    localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_reg;
    logic             owner_reg;
    logic             last_grant_reg;
    logic             lock_active_reg;
    logic [CNT_W-1:0] idle_cnt_reg;

    logic [ADDR_W-1:0]    host_addr  [2];
    logic [REG_WIDTH-1:0] host_wdata [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_host
        assign host_addr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
        assign host_wdata[gi] = bus.wdata[gi*REG_WIDTH +: REG_WIDTH];
    end

    logic grant_valid;
    logic grant_id;

    // A held lock narrows eligibility to the owner; otherwise resolve conflicts.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (lock_active_reg) begin
            grant_valid = bus.req[owner_reg];
            grant_id    = owner_reg;
        end else if (bus.req == 2'b11) begin
            grant_valid = 1'b1;
            grant_id    = prio_mode ? 1'b0 : ~last_grant_reg;
        end else if (bus.req[0]) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (bus.req[1]) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg       <= IDLE;
            owner_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            lock_active_reg <= 1'b0;
            idle_cnt_reg    <= '0;
            timeout         <= 1'b0;
            bus.ack         <= '0;
            bus.err         <= '0;
            bus.rdata       <= '0;
            bus.bank_wr_rdn <= 1'b0;
            bus.bank_addr   <= '0;
            bus.bank_wdata  <= '0;
            bus.bank_we     <= 1'b0;
        end else begin
            bus.ack <= '0;
            bus.err <= '0;
            timeout <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ena && grant_valid) begin
                        owner_reg       <= grant_id;
                        bus.bank_wr_rdn <= bus.wr_rdn[grant_id];
                        bus.bank_addr   <= host_addr[grant_id];
                        bus.bank_wdata  <= host_wdata[grant_id];
                        bus.bank_we     <= bus.wr_rdn[grant_id];
                        state_reg       <= ISSUE;
                    end
                    // Owner dropping lock releases at once; an idle owner ages out.
                    if (lock_active_reg) begin
                        if (!bus.lock[owner_reg]) begin
                            lock_active_reg <= 1'b0;
                            idle_cnt_reg    <= '0;
                        end else if (ena && !bus.req[owner_reg]) begin
                            if (idle_cnt_reg == CNT_MAX) begin
                                lock_active_reg <= 1'b0;
                                idle_cnt_reg    <= '0;
                                timeout         <= 1'b1;
                            end else begin
                                idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                end
                ISSUE: begin
                    bus.bank_we <= 1'b0;
                    if (!bus.bank_wr_rdn) begin
                        bus.rdata <= bus.bank_rdata;
                    end
                    bus.err[owner_reg] <= bus.bank_err;
                    bus.ack[owner_reg] <= 1'b1;
                    state_reg          <= RESP;
                end
                RESP: begin
                    last_grant_reg  <= owner_reg;
                    lock_active_reg <= bus.lock[owner_reg];
                    idle_cnt_reg    <= '0;
                    state_reg       <= IDLE;
                end
                default: begin
                    state_reg   <= IDLE;
                    bus.bank_we <= 1'b0;
                end
            endcase
        end
    end
endmodule
